irq_arbiter: RTL and testbench

- Collects 8 asynchronous external interrupt lines and latches edges into a pending register.
- Applies the software mask and arbitrates by fixed priority.
- Drives int_pending and int_vector to the microcode sequencer.
- Services the sequencer's int_ack, irq_masks_wrt, int_vector_wrt and clear_all_ints control strobes. Sits between the board interrupt pins and the microcode sequencer/trap microroutine.

---
 rtl/irq_arbiter_if.sv | 65 ++++++
 rtl/irq_arbiter.sv | 168 ++++++++++++++++
 tb/tb_irq_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_if.sv
// ----------------------------------------------------------------------------
// irq_arbiter_if
//   Bundles the sequencer-facing signals of the interrupt arbiter.
//
//   Configuration macro: IRQ_ARBITER_SPURIOUS_EN adds the sticky spurious_irq
//   status bit to the bundle.
//
//   Signals:
//     z_bus               8  data source for mask / vector-base writes
//     ctrl_irq_masks_wrt  1  load irq_masks from z_bus
//     ctrl_int_vector_wrt 1  load vector_base from z_bus[7:4]
//     ctrl_int_ack        1  one-cycle acknowledge from trap microcode
//     ctrl_clear_all_ints 1  clear all pending bits and abort service
//     status_irq_en       1  CPU status interrupt enable
//     int_pending         1  qualified request to the sequencer
//     int_vector          8  vector of the last acknowledged interrupt
//     irq_masks           8  current mask register (1 = enabled)
//     irq_pending         8  raw pending register
//     in_service          1  high while an interrupt is being serviced
//     spurious_irq        1  sticky spurious-ack flag (macro builds only)
//
//   Modports: master = sequencer side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface irq_arbiter_if;
    logic [7:0] z_bus;
    logic       ctrl_irq_masks_wrt;
    logic       ctrl_int_vector_wrt;
    logic       ctrl_int_ack;
    logic       ctrl_clear_all_ints;
    logic       status_irq_en;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] irq_masks;
    logic [7:0] irq_pending;
    logic       in_service;
`ifdef IRQ_ARBITER_SPURIOUS_EN
    logic       spurious_irq;

    modport master (
        output z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack,
               ctrl_clear_all_ints, status_irq_en,
        input  int_pending, int_vector, irq_masks, irq_pending, in_service,
               spurious_irq
    );

    modport slave (
        input  z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack,
               ctrl_clear_all_ints, status_irq_en,
        output int_pending, int_vector, irq_masks, irq_pending, in_service,
               spurious_irq
    );
`else
    modport master (
        output z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack,
               ctrl_clear_all_ints, status_irq_en,
        input  int_pending, int_vector, irq_masks, irq_pending, in_service
    );

    modport slave (
        input  z_bus, ctrl_irq_masks_wrt, ctrl_int_vector_wrt, ctrl_int_ack,
               ctrl_clear_all_ints, status_irq_en,
        output int_pending, int_vector, irq_masks, irq_pending, in_service
    );
`endif
endinterface

// File: rtl/irq_arbiter.sv
// ----------------------------------------------------------------------------
// irq_arbiter
//   Synchronises 8 asynchronous rising-edge interrupt lines, latches edges
//   into a pending register, masks them, picks a fixed-priority winner and
//   hands it to the microcode sequencer through an int_pending / int_ack
//   handshake. The acknowledged interrupt is reported on int_vector as
//   {vector_base, winner[2:0], 1'b0}.
//
//   Configuration macro: IRQ_ARBITER_SPURIOUS_EN. When defined, an ack that
//   arrives outside the PENDING state loads int_vector with 8'hFF and sets
//   the sticky spurious_irq flag (cleared by ctrl_clear_all_ints). When
//   undefined such acks are silently ignored.
//
//   Parameters:
//     SYNC_STAGES   synchroniser flops per irq line (2..4)
//     MASK_RESET    irq_masks value after reset
//     LSB_HIGH_PRIO 1: irq_in[0] wins, 0: irq_in[7] wins
//
//   Ports:
//     clk     system clock, all state on posedge
//     arst    asynchronous active-high reset
//     irq_in  asynchronous interrupt request lines
//     bus     sequencer-side signals (irq_arbiter_if.slave)
// ----------------------------------------------------------------------------
module irq_arbiter #(
    parameter int       SYNC_STAGES   = 2,
    parameter logic [7:0] MASK_RESET  = 8'h00,
    parameter bit       LSB_HIGH_PRIO = 1'b1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [7:0]    irq_in,
    irq_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] edge_q, edge_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] base_q, base_d;
    logic [7:0] vector_q, vector_d;
`ifdef IRQ_ARBITER_SPURIOUS_EN
    logic       spurious_q, spurious_d;
`endif

    logic [7:0] rise;
    logic [7:0] qualified;
    logic [2:0] winner;
    logic       ack_valid;
    logic [7:0] ack_clear;
    logic       int_pending_w;
    logic       in_service_w;

    // Scan from lowest to highest priority so the last hit is the winner.
    function automatic logic [2:0] pick_winner(input logic [7:0] req);
        logic [2:0] idx;
        int         j;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            j = LSB_HIGH_PRIO ? (7 - i) : i;
            if (req[j]) idx = j[2:0];
        end
        return idx;
    endfunction

    // Synchroniser chain; the edge flop holds the previous synchronised value.
    always_comb begin
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        edge_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    // Pending/mask/vector datapath. Acks only count in PENDING with a live
    // winner; clear_all dominates everything, and a fresh edge on the ack'd
    // bit re-sets it because rise is OR-ed in after the ack clear.
    always_comb begin
        qualified = pending_q & mask_q;
        winner    = pick_winner(qualified);
        ack_valid = bus.ctrl_int_ack && (state_q == ST_PENDING) && (|qualified);
        ack_clear = ack_valid ? (8'd1 << winner) : 8'h00;

        pending_d = bus.ctrl_clear_all_ints ? 8'h00 : ((pending_q & ~ack_clear) | rise);
        mask_d    = bus.ctrl_irq_masks_wrt  ? bus.z_bus      : mask_q;
        base_d    = bus.ctrl_int_vector_wrt ? bus.z_bus[7:4] : base_q;

        vector_d = vector_q;
        if (!bus.ctrl_clear_all_ints && ack_valid) vector_d = {base_q, winner, 1'b0};
`ifdef IRQ_ARBITER_SPURIOUS_EN
        spurious_d = spurious_q;
        if (bus.ctrl_clear_all_ints) begin
            spurious_d = 1'b0;
        end else if (bus.ctrl_int_ack && (state_q != ST_PENDING)) begin
            spurious_d = 1'b1;
            vector_d   = 8'hFF;
        end
`endif
    end

    // State register plus all datapath flops.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
            edge_q    <= 8'h00;
            pending_q <= 8'h00;
            mask_q    <= MASK_RESET;
            base_q    <= 4'h0;
            vector_q  <= 8'h00;
`ifdef IRQ_ARBITER_SPURIOUS_EN
            spurious_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            edge_q    <= edge_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            base_q    <= base_d;
            vector_q  <= vector_d;
`ifdef IRQ_ARBITER_SPURIOUS_EN
            spurious_q <= spurious_d;
`endif
        end
    end

    // Next-state logic. An ack wins over a simultaneous withdrawal.
    always_comb begin
        state_d = state_q;
        if (bus.ctrl_clear_all_ints) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    if ((|qualified) && bus.status_irq_en) state_d = ST_PENDING;
                ST_PENDING: begin
                    if (ack_valid)                                   state_d = ST_SERVICE;
                    else if (!(|qualified) || !bus.status_irq_en)    state_d = ST_IDLE;
                end
                ST_SERVICE: if (!bus.status_irq_en)                  state_d = ST_IDLE;
                default:                                             state_d = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs; they come straight from the state flop.
    always_comb begin
        int_pending_w = (state_q == ST_PENDING);
        in_service_w  = (state_q == ST_SERVICE);
    end

    assign bus.int_pending = int_pending_w;
    assign bus.in_service  = in_service_w;
    assign bus.int_vector  = vector_q;
    assign bus.irq_masks   = mask_q;
    assign bus.irq_pending = pending_q;
`ifdef IRQ_ARBITER_SPURIOUS_EN
    assign bus.spurious_irq = spurious_q;
`endif

endmodule

// File: tb/tb_irq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_irq_arbiter
//   Self-checking bench for irq_arbiter: a hand-derived vector table, directed
//   sequences for the multi-cycle corner cases, and a randomized run compared
//   every cycle against a behavioural model of the arbiter.
// ----------------------------------------------------------------------------
module tb_irq_arbiter;

    localparam int         S        = 2;
    localparam logic [7:0] MASK_RST = 8'h00;
    localparam bit         LSB_PRIO = 1'b1;

    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_SERV = 2;

    logic       clk;
    logic       arst;
    logic [7:0] irq_in;

    int checks;
    int errors;

    irq_arbiter_if bus ();

    irq_arbiter #(
        .SYNC_STAGES  (S),
        .MASK_RESET   (MASK_RST),
        .LSB_HIGH_PRIO(LSB_PRIO)
    ) dut (
        .clk   (clk),
        .arst  (arst),
        .irq_in(irq_in),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state.
    logic [7:0] m_pending, m_mask, m_vec;
    logic [3:0] m_base;
    logic       m_spur;
    int         m_state;
    logic [7:0] hist[$];

    typedef struct {
        logic [7:0] irq;
        logic [7:0] z;
        logic       mwr, vwr, ack, clr, en;
        logic [7:0] e_pend, e_mask, e_vec;
        logic       e_intp, e_svc;
    } vec_t;

    vec_t tbl[10];

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] irq, input logic [7:0] z, input logic mwr,
                                 input logic vwr, input logic ack, input logic clr, input logic en);
        irq_in                  = irq;
        bus.z_bus               = z;
        bus.ctrl_irq_masks_wrt  = mwr;
        bus.ctrl_int_vector_wrt = vwr;
        bus.ctrl_int_ack        = ack;
        bus.ctrl_clear_all_ints = clr;
        bus.status_irq_en       = en;
    endtask

    task automatic model_reset();
        m_pending = 8'h00;
        m_mask    = MASK_RST;
        m_vec     = 8'h00;
        m_base    = 4'h0;
        m_spur    = 1'b0;
        m_state   = M_IDLE;
        hist.delete();
        for (int i = 0; i < S + 1; i++) hist.push_back(8'h00);
    endtask

    // One clock of the model. hist holds irq_in as sampled at past edges;
    // an edge reaches the pending register S edges after it is first sampled.
    task automatic model_step();
        logic [7:0] qual, rise, n_pend, n_vec;
        int         w, n_state;
        bit         acc, n_spur;
        rise = hist[hist.size()-S] & ~hist[hist.size()-S-1];
        hist.push_back(irq_in);
        if (hist.size() > S + 2) void'(hist.pop_front());

        qual = m_pending & m_mask;
        w = -1;
        for (int i = 0; i < 8; i++) begin
            int k;
            k = LSB_PRIO ? i : 7 - i;
            if (qual[k] && w < 0) w = k;
        end
        acc = bus.ctrl_int_ack && (m_state == M_PEND) && (w >= 0);

        n_pend  = m_pending;
        n_vec   = m_vec;
        n_state = m_state;
        n_spur  = m_spur;
        if (bus.ctrl_clear_all_ints) begin
            n_pend  = 8'h00;
            n_state = M_IDLE;
            n_spur  = 1'b0;
        end else begin
            if (acc) n_pend[w] = 1'b0;
            n_pend = n_pend | rise;
            if (acc) n_vec = {m_base, 3'(w), 1'b0};
`ifdef IRQ_ARBITER_SPURIOUS_EN
            if (bus.ctrl_int_ack && m_state != M_PEND) begin
                n_vec  = 8'hFF;
                n_spur = 1'b1;
            end
`endif
            if (m_state == M_IDLE && qual != 0 && bus.status_irq_en) n_state = M_PEND;
            else if (m_state == M_PEND) begin
                if (acc) n_state = M_SERV;
                else if (qual == 0 || !bus.status_irq_en) n_state = M_IDLE;
            end else if (m_state == M_SERV && !bus.status_irq_en) n_state = M_IDLE;
        end
        if (bus.ctrl_irq_masks_wrt)  m_mask = bus.z_bus;
        if (bus.ctrl_int_vector_wrt) m_base = bus.z_bus[7:4];
        m_pending = n_pend;
        m_vec     = n_vec;
        m_state   = n_state;
        m_spur    = n_spur;
    endtask

    task automatic compare_model();
        checkOutput("model_irq_pending", bus.irq_pending, m_pending);
        checkOutput("model_irq_masks",   bus.irq_masks,   m_mask);
        checkOutput("model_int_vector",  bus.int_vector,  m_vec);
        checkOutput("model_int_pending", {7'd0, bus.int_pending}, {7'd0, m_state == M_PEND});
        checkOutput("model_in_service",  {7'd0, bus.in_service},  {7'd0, m_state == M_SERV});
`ifdef IRQ_ARBITER_SPURIOUS_EN
        checkOutput("model_spurious_irq", {7'd0, bus.spurious_irq}, {7'd0, m_spur});
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        arst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        arst = 1'b0;
        model_reset();
        checkOutput("reset_irq_pending", bus.irq_pending, 8'h00);
        checkOutput("reset_irq_masks",   bus.irq_masks,   MASK_RST);
        checkOutput("reset_int_vector",  bus.int_vector,  8'h00);
        checkOutput("reset_int_pending", {7'd0, bus.int_pending}, 8'h00);
        checkOutput("reset_in_service",  {7'd0, bus.in_service},  8'h00);
    endtask

    task automatic wait_intp(input string name, input int limit);
        int n;
        n = 0;
        while (!bus.int_pending && n < limit) begin
            step();
            n++;
        end
        checkOutput(name, {7'd0, bus.int_pending}, 8'h01);
    endtask

    // Mask all-on, set the vector base and take one interrupt into PENDING.
    task automatic setup_pending(input logic [7:0] irq, input logic [7:0] base_z, input string name);
        do_reset();
        applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); step();
        applyStimulus(8'h00, base_z, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); step();
        applyStimulus(irq, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step(); step();
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_intp(name, 20);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] r_irq;
        checks = 0;
        errors = 0;
        arst   = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // irq / z / mwr vwr ack clr en / pend mask vec intp svc
        tbl[0] = '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h08, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h08, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'h08, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 8'hA6, 1'b0, 1'b1};
        tbl[8] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 8'hA6, 1'b0, 1'b0};
        tbl[9] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h08, 8'hA6, 1'b0, 1'b0};

        // Vector table: masked latch, unmask, base write, ack, drop, clear.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].irq, tbl[i].z, tbl[i].mwr, tbl[i].vwr, tbl[i].ack,
                          tbl[i].clr, tbl[i].en);
            step();
            checkOutput($sformatf("tbl%0d_pending", i), bus.irq_pending, tbl[i].e_pend);
            checkOutput($sformatf("tbl%0d_masks", i),   bus.irq_masks,   tbl[i].e_mask);
            checkOutput($sformatf("tbl%0d_vector", i),  bus.int_vector,  tbl[i].e_vec);
            checkOutput($sformatf("tbl%0d_intp", i),    {7'd0, bus.int_pending}, {7'd0, tbl[i].e_intp});
            checkOutput($sformatf("tbl%0d_insvc", i),   {7'd0, bus.in_service},  {7'd0, tbl[i].e_svc});
        end

        // Two simultaneous edges: bit 2 wins, then bit 5 after re-enable.
        setup_pending(8'h24, 8'hA0, "seqA_intp");
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step();
        checkOutput("seqA_vec1",  bus.int_vector, 8'hA4);
        checkOutput("seqA_pend",  bus.irq_pending, 8'h20);
        checkOutput("seqA_svc",   {7'd0, bus.in_service}, 8'h01);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        checkOutput("seqA_idle",  {7'd0, bus.in_service}, 8'h00);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        checkOutput("seqA_reint", {7'd0, bus.int_pending}, 8'h01);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step();
        checkOutput("seqA_vec2",  bus.int_vector, 8'hAA);

        // clear_all in the same cycle that a new edge on bit 1 lands.
        setup_pending(8'h01, 8'h00, "seqB_intp");
        checkOutput("seqB_pend0", bus.irq_pending, 8'h01);
        applyStimulus(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (S) step();
        applyStimulus(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step();
        checkOutput("seqB_pend",  bus.irq_pending, 8'h00);
        checkOutput("seqB_intp0", {7'd0, bus.int_pending}, 8'h00);
        applyStimulus(8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step(); step();
        checkOutput("seqB_lost",  bus.irq_pending, 8'h00);

        // Ack of bit 0 coinciding with a fresh bit-0 edge.
        setup_pending(8'h01, 8'h30, "seqC_intp");
        step(); step();
        applyStimulus(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (S) step();
        applyStimulus(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step();
        checkOutput("seqC_pend", bus.irq_pending, 8'h01);
        checkOutput("seqC_vec",  bus.int_vector, 8'h30);
        checkOutput("seqC_svc",  {7'd0, bus.in_service}, 8'h01);

        // Second ack while in SERVICE.
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step();
`ifdef IRQ_ARBITER_SPURIOUS_EN
        checkOutput("seqD_vec",  bus.int_vector, 8'hFF);
        checkOutput("seqD_spur", {7'd0, bus.spurious_irq}, 8'h01);
`else
        checkOutput("seqD_vec",  bus.int_vector, 8'h30);
`endif
        checkOutput("seqD_svc",  {7'd0, bus.in_service}, 8'h01);
        checkOutput("seqD_pend", bus.irq_pending, 8'h01);

        // Asynchronous reset in the middle of service.
        setup_pending(8'h38, 8'h50, "seqE_intp");
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); step();
        checkOutput("seqE_pend", bus.irq_pending, 8'h30);
        checkOutput("seqE_vec",  bus.int_vector, 8'h56);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2 arst = 1'b1;
        #1;
        checkOutput("seqE_rst_pend", bus.irq_pending, 8'h00);
        checkOutput("seqE_rst_mask", bus.irq_masks, MASK_RST);
        checkOutput("seqE_rst_vec",  bus.int_vector, 8'h00);
        checkOutput("seqE_rst_intp", {7'd0, bus.int_pending}, 8'h00);
        checkOutput("seqE_rst_svc",  {7'd0, bus.in_service}, 8'h00);
        @(posedge clk);
        #1 arst = 1'b0;
        model_reset();

        // Randomized run against the model.
        do_reset();
        r_irq = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            r_irq = r_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            applyStimulus(r_irq, 8'($urandom),
                          ($urandom % 16) == 0, ($urandom % 16) == 0,
                          ($urandom % 4) == 0,  ($urandom % 40) == 0,
                          ($urandom % 8) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
